// File: rtl/fir_top_axi4lite.sv
// AXI4-Lite register block: 32 input samples, 4-tap FIR [1 2 2 1] over one run, 32 output words.
// Write/read responses arrive one cycle after acceptance; one outstanding transfer per channel; run takes 32 cycles.
module fir_top_axi4lite (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] i_axi_awaddr,
    input  logic        i_axi_awvalid,
    output logic        o_axi_awready,
    input  logic [3:0]  i_axi_awcache,
    input  logic [2:0]  i_axi_awprot,
    input  logic [31:0] i_axi_wdata,
    input  logic [3:0]  i_axi_wstrb,
    input  logic        i_axi_wvalid,
    output logic        o_axi_wready,
    output logic [1:0]  o_axi_bresp,
    output logic        o_axi_bvalid,
    input  logic        i_axi_bready,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    input  logic [3:0]  i_axi_arcache,
    input  logic [2:0]  i_axi_arprot,
    output logic [31:0] o_axi_rdata,
    output logic [1:0]  o_axi_rresp,
    output logic        o_axi_rvalid,
    input  logic        i_axi_rready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        start_q;
    logic        done_q;
    logic [15:0] in_mem  [32];
    logic [31:0] out_mem [32];

    logic        wr_hs, rd_hs;
    logic [7:0]  wr_word, rd_word;
    logic        wr_map, rd_map;
    logic        wr_start, wr_in, start_new, launch;
    logic [31:0] rd_mux;
    logic [4:0]  idx1, idx2, idx3;
    logic [31:0] x0, x1, x2, x3, fir;
    logic        unused_ok;

    function automatic logic [31:0] sext(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

    assign o_axi_bresp = 2'b00;
    assign o_axi_rresp = 2'b00;

    assign unused_ok = ^{i_axi_awcache, i_axi_awprot, i_axi_arcache, i_axi_arprot,
                         i_axi_wdata[31:16], i_axi_wstrb[3:2],
                         i_axi_awaddr[1:0], i_axi_araddr[1:0]};

    assign wr_hs     = i_axi_awvalid && i_axi_wvalid && o_axi_awready && o_axi_wready;
    assign rd_hs     = i_axi_arvalid && o_axi_arready;
    assign wr_word   = i_axi_awaddr[9:2];
    assign rd_word   = i_axi_araddr[9:2];
    assign wr_map    = (i_axi_awaddr[31:10] == 22'd0);
    assign rd_map    = (i_axi_araddr[31:10] == 22'd0);
    assign wr_start  = wr_hs && wr_map && (wr_word == 8'h00);
    assign wr_in     = wr_hs && wr_map && (wr_word[7:5] == 3'b010);
    assign start_new = i_axi_wstrb[0] ? i_axi_wdata[0] : start_q;
    assign launch    = wr_start && start_new && !start_q && (state == IDLE);

    always_comb begin
        rd_mux = '0;
        if (rd_map) begin
            if (rd_word == 8'h00)
                rd_mux = {31'd0, start_q};
            else if (rd_word == 8'h01)
                rd_mux = {31'd0, done_q};
            else if (rd_word[7:5] == 3'b010)
                rd_mux = sext(in_mem[rd_word[4:0]]);
            else if (rd_word[7:5] == 3'b100)
                rd_mux = out_mem[rd_word[4:0]];
        end
    end

    // Taps before sample 0 are treated as zero rather than wrapping around the buffer.
    assign idx1 = cnt - 5'd1;
    assign idx2 = cnt - 5'd2;
    assign idx3 = cnt - 5'd3;

    always_comb begin
        x0  = sext(in_mem[cnt]);
        x1  = (cnt >= 5'd1) ? sext(in_mem[idx1]) : 32'd0;
        x2  = (cnt >= 5'd2) ? sext(in_mem[idx2]) : 32'd0;
        x3  = (cnt >= 5'd3) ? sext(in_mem[idx3]) : 32'd0;
        fir = x0 + {x1[30:0], 1'b0} + {x2[30:0], 1'b0} + x3;
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b0;
            o_axi_bvalid  <= 1'b0;
            o_axi_arready <= 1'b0;
            o_axi_rvalid  <= 1'b0;
            o_axi_rdata   <= '0;
        end else begin
            o_axi_awready <= i_axi_awvalid && i_axi_wvalid && !o_axi_awready && !o_axi_bvalid;
            o_axi_wready  <= i_axi_awvalid && i_axi_wvalid && !o_axi_awready && !o_axi_bvalid;
            if (wr_hs)
                o_axi_bvalid <= 1'b1;
            else if (i_axi_bready)
                o_axi_bvalid <= 1'b0;

            o_axi_arready <= i_axi_arvalid && !o_axi_arready && !o_axi_rvalid;
            if (rd_hs) begin
                o_axi_rvalid <= 1'b1;
                o_axi_rdata  <= rd_mux;
            end else if (i_axi_rready) begin
                o_axi_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                in_mem[i]  <= '0;
                out_mem[i] <= '0;
            end
        end else begin
            if (wr_start && i_axi_wstrb[0])
                start_q <= i_axi_wdata[0];
            if (wr_in && state == IDLE) begin
                if (i_axi_wstrb[0]) in_mem[wr_word[4:0]][7:0]  <= i_axi_wdata[7:0];
                if (i_axi_wstrb[1]) in_mem[wr_word[4:0]][15:8] <= i_axi_wdata[15:8];
            end
            case (state)
                IDLE: begin
                    if (launch) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        done_q <= 1'b0;
                    end
                end
                BUSY: begin
                    out_mem[cnt] <= fir;
                    cnt          <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_top_axi4lite.sv
// Directed bench for fir_top_axi4lite: register access, FIR results, run timing, busy/reset behaviour.
module tb_fir_top_axi4lite;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [31:0] i_axi_awaddr = '0;
    logic        i_axi_awvalid = 1'b0;
    logic        o_axi_awready;
    logic [31:0] i_axi_wdata = '0;
    logic [3:0]  i_axi_wstrb = '0;
    logic        i_axi_wvalid = 1'b0;
    logic        o_axi_wready;
    logic [1:0]  o_axi_bresp;
    logic        o_axi_bvalid;
    logic        i_axi_bready = 1'b0;
    logic [31:0] i_axi_araddr = '0;
    logic        i_axi_arvalid = 1'b0;
    logic        o_axi_arready;
    logic [31:0] o_axi_rdata;
    logic [1:0]  o_axi_rresp;
    logic        o_axi_rvalid;
    logic        i_axi_rready = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int wr_cyc = 0;

    localparam logic [31:0] A_START = 32'h000;
    localparam logic [31:0] A_DONE  = 32'h004;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    fir_top_axi4lite dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_axi_awaddr  (i_axi_awaddr),
        .i_axi_awvalid (i_axi_awvalid),
        .o_axi_awready (o_axi_awready),
        .i_axi_awcache (4'h3),
        .i_axi_awprot  (3'h2),
        .i_axi_wdata   (i_axi_wdata),
        .i_axi_wstrb   (i_axi_wstrb),
        .i_axi_wvalid  (i_axi_wvalid),
        .o_axi_wready  (o_axi_wready),
        .o_axi_bresp   (o_axi_bresp),
        .o_axi_bvalid  (o_axi_bvalid),
        .i_axi_bready  (i_axi_bready),
        .i_axi_araddr  (i_axi_araddr),
        .i_axi_arvalid (i_axi_arvalid),
        .o_axi_arready (o_axi_arready),
        .i_axi_arcache (4'h3),
        .i_axi_arprot  (3'h2),
        .o_axi_rdata   (o_axi_rdata),
        .o_axi_rresp   (o_axi_rresp),
        .o_axi_rvalid  (o_axi_rvalid),
        .i_axi_rready  (i_axi_rready)
    );

    // Records the acceptance cycle in wr_cyc.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(posedge clk_i); #1;
        i_axi_awaddr = a; i_axi_wdata = d; i_axi_wstrb = s;
        i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!(o_axi_awready && o_axi_wready) && n < 50) begin @(negedge clk_i); n++; end
        if (!(o_axi_awready && o_axi_wready)) begin
            nvec++; nerr++;
            $display("FAIL aw_timeout: addr %h not accepted in 50 cycles", a);
        end
        wr_cyc = cyc;
        @(posedge clk_i); #1;
        i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0; i_axi_bready = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!o_axi_bvalid && n < 50) begin @(negedge clk_i); n++; end
        if (!o_axi_bvalid) begin
            nvec++; nerr++;
            $display("FAIL b_timeout: no bvalid for addr %h", a);
        end
        resp = o_axi_bresp;
        @(posedge clk_i); #1;
        i_axi_bready = 1'b0;
    endtask

    // h > 0 places the address handshake exactly in cycle h.
    task automatic axi_read(input logic [31:0] a, input int h, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        if (h > 0) begin
            while (cyc < h - 1) begin @(posedge clk_i); #1; end
            nvec++;
            if (cyc != h - 1) begin
                nerr++;
                $display("FAIL read_slot: issue cycle %0d, required %0d", cyc, h - 1);
            end
        end else begin
            @(posedge clk_i); #1;
        end
        i_axi_araddr = a; i_axi_arvalid = 1'b1; i_axi_rready = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!o_axi_arready && n < 50) begin @(negedge clk_i); n++; end
        if (!o_axi_arready) begin
            nvec++; nerr++;
            $display("FAIL ar_timeout: addr %h not accepted", a);
        end
        @(posedge clk_i); #1;
        i_axi_arvalid = 1'b0;
        n = 0;
        @(negedge clk_i);
        while (!o_axi_rvalid && n < 50) begin @(negedge clk_i); n++; end
        if (!o_axi_rvalid) begin
            nvec++; nerr++;
            $display("FAIL r_timeout: no rvalid for addr %h", a);
        end
        d = o_axi_rdata;
        resp = o_axi_rresp;
        @(posedge clk_i); #1;
        i_axi_rready = 1'b0;
    endtask

    task automatic load_ramp();
        logic [1:0] r;
        for (int i = 0; i < 32; i++)
            axi_write(32'h100 + 32'(4 * i), 32'(4 * i), 4'hF, r);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        d = '0;
        for (int k = 0; k < 20 && d[0] !== 1'b1; k++)
            axi_read(A_DONE, 0, d, r);
        nvec++;
        if (d !== 32'd1) begin
            nerr++;
            $display("FAIL %s_done_poll: DONE=%h required 00000001", tag, d);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int rel, n;
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        nvec++;
        if ({o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_arready, o_axi_rvalid, o_axi_rdata} !== 37'd0) begin
            nerr++;
            $display("FAIL reset_outputs: aw%b w%b b%b ar%b r%b rdata=%h, required all 0",
                     o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_arready, o_axi_rvalid, o_axi_rdata);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        rel = cyc;
        i_axi_awaddr = 32'h300; i_axi_wdata = 32'h5A5A5A5A; i_axi_wstrb = 4'hF;
        i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!o_axi_awready && n < 10) begin @(negedge clk_i); n++; end
        nvec++;
        if (!o_axi_awready || cyc - rel > 2) begin
            nerr++;
            $display("FAIL first_accept: accepted %0d cycles after release, required <= 2", cyc - rel);
        end
        @(posedge clk_i); #1;
        i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0; i_axi_bready = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!o_axi_bvalid && n < 10) begin @(negedge clk_i); n++; end
        nvec++;
        if (o_axi_bvalid !== 1'b1 || o_axi_bresp !== 2'b00) begin
            nerr++;
            $display("FAIL first_bresp: bvalid=%b bresp=%b, required 1/00", o_axi_bvalid, o_axi_bresp);
        end
        @(posedge clk_i); #1;
        i_axi_bready = 1'b0;

        axi_read(A_DONE, 0, d, r);
        nvec++;
        if (d !== 32'd0 || r !== 2'b00) begin
            nerr++; $display("FAIL reset_done: got %h/%b required 00000000/00", d, r);
        end
        axi_read(32'h214, 0, d, r);
        nvec++;
        if (d !== 32'd0 || r !== 2'b00) begin
            nerr++; $display("FAIL reset_out5: got %h/%b required 00000000/00", d, r);
        end
        axi_read(32'h100, 0, d, r);
        nvec++;
        if (d !== 32'd0 || r !== 2'b00) begin
            nerr++; $display("FAIL reset_in0: got %h/%b required 00000000/00", d, r);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h114, 32'h00001234, 4'hF, r);
        axi_write(32'h116, 32'h7777AB00, 4'b0010, r);
        axi_read(32'h114, 0, d, r);
        nvec++;
        if (d !== 32'hFFFFAB34) begin
            nerr++; $display("FAIL in5_strobe_sext: got %h required ffffab34", d);
        end
        axi_write(32'h300, 32'hCAFEF00D, 4'hF, r);
        axi_read(32'h300, 0, d, r);
        nvec++;
        if (d !== 32'd0 || r !== 2'b00) begin
            nerr++; $display("FAIL unmapped_read: got %h/%b required 00000000/00", d, r);
        end
        axi_read(32'h1000_0114, 0, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL alias_read: got %h required 00000000", d);
        end
        axi_write(32'h200, 32'hDEADBEEF, 4'hF, r);
        axi_read(32'h200, 0, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL out_write_ignored: got %h required 00000000", d);
        end
        axi_write(A_DONE, 32'h1, 4'hF, r);
        axi_write(A_START, 32'h1, 4'h0, r);
        axi_read(A_START, 0, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL start_strobe_gated: got %h required 00000000", d);
        end
        repeat (40) @(posedge clk_i);
        #1;
        axi_read(A_DONE, 0, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL done_not_writable: got %h required 00000000", d);
        end
    endtask

    task automatic test_ramp();
        logic [31:0] d, e;
        logic [1:0]  r;
        int t;
        load_ramp();
        axi_write(A_START, 32'h1, 4'hF, r);
        t = wr_cyc;
        nvec++;
        if (r !== 2'b00) begin
            nerr++; $display("FAIL start_bresp: got %b required 00", r);
        end
        axi_read(A_DONE, t + 32, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL ramp_done_t32: got %h required 00000000", d);
        end
        wait_done("ramp");
        axi_write(A_START, 32'h0, 4'hF, r);
        for (int n = 0; n < 32; n++) begin
            e = (n == 0) ? 32'h0 : (n == 1) ? 32'h4 : (n == 2) ? 32'h10 : 32'(24 * n - 36);
            axi_read(32'h200 + 32'(4 * n), 0, d, r);
            nvec++;
            if (d !== e) begin
                nerr++; $display("FAIL ramp_out[%0d]: got %h required %h", n, d, e);
            end
        end
    endtask

    task automatic test_impulse();
        logic [31:0] d, e;
        logic [1:0]  r;
        for (int i = 0; i < 32; i++)
            axi_write(32'h100 + 32'(4 * i), (i == 0) ? 32'd1 : 32'd0, 4'hF, r);
        axi_write(A_START, 32'h1, 4'hF, r);
        axi_write(A_START, 32'h0, 4'hF, r);
        wait_done("impulse");
        for (int n = 0; n < 32; n++) begin
            e = (n == 0 || n == 3) ? 32'd1 : (n == 1 || n == 2) ? 32'd2 : 32'd0;
            axi_read(32'h200 + 32'(4 * n), 0, d, r);
            nvec++;
            if (d !== e) begin
                nerr++; $display("FAIL impulse_out[%0d]: got %h required %h", n, d, e);
            end
        end
    endtask

    task automatic test_negative();
        logic [31:0] d, e;
        logic [1:0]  r;
        for (int i = 0; i < 32; i++)
            axi_write(32'h100 + 32'(4 * i), 32'h0000FFFF, 4'b0011, r);
        axi_read(32'h11C, 0, d, r);
        nvec++;
        if (d !== 32'hFFFFFFFF) begin
            nerr++; $display("FAIL neg_in7: got %h required ffffffff", d);
        end
        axi_write(A_START, 32'h1, 4'hF, r);
        axi_write(A_START, 32'h0, 4'hF, r);
        wait_done("neg");
        for (int n = 0; n < 32; n++) begin
            e = (n == 0) ? 32'hFFFFFFFF : (n == 1) ? 32'hFFFFFFFD : (n == 2) ? 32'hFFFFFFFB : 32'hFFFFFFFA;
            axi_read(32'h200 + 32'(4 * n), 0, d, r);
            nvec++;
            if (d !== e) begin
                nerr++; $display("FAIL neg_out[%0d]: got %h required %h", n, d, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        logic [1:0]  r;
        int t;
        load_ramp();
        axi_write(A_START, 32'h1, 4'hF, r);
        t = wr_cyc;
        axi_read(A_DONE, t + 3, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL busy_done_cleared: got %h required 00000000", d);
        end
        while (cyc < t + 10) begin @(posedge clk_i); #1; end
        axi_write(A_START, 32'h0, 4'hF, r);
        axi_write(A_START, 32'h1, 4'hF, r);
        axi_write(32'h10C, 32'h00007777, 4'hF, r);
        axi_write(A_START, 32'h0, 4'hF, r);
        axi_read(A_DONE, t + 33, d, r);
        nvec++;
        if (d !== 32'd1) begin
            nerr++; $display("FAIL busy_done_t33: got %h required 00000001", d);
        end
        axi_read(32'h10C, 0, d, r);
        nvec++;
        if (d !== 32'd12) begin
            nerr++; $display("FAIL busy_in3_kept: got %h required 0000000c", d);
        end
        for (int n = 0; n < 32; n++) begin
            e = (n == 0) ? 32'h0 : (n == 1) ? 32'h4 : (n == 2) ? 32'h10 : 32'(24 * n - 36);
            axi_read(32'h200 + 32'(4 * n), 0, d, r);
            nvec++;
            if (d !== e) begin
                nerr++; $display("FAIL busy_out[%0d]: got %h required %h", n, d, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d, e;
        logic [1:0]  r;
        int t;
        load_ramp();
        axi_write(A_START, 32'h1, 4'hF, r);
        t = wr_cyc;
        while (cyc < t + 10) begin @(posedge clk_i); #1; end
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        axi_read(A_DONE, 0, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL abort_done: got %h required 00000000", d);
        end
        axi_read(32'h110, 0, d, r);
        nvec++;
        if (d !== 32'd0) begin
            nerr++; $display("FAIL abort_in4: got %h required 00000000", d);
        end
        for (int n = 0; n < 32; n++) begin
            axi_read(32'h200 + 32'(4 * n), 0, d, r);
            nvec++;
            if (d !== 32'd0) begin
                nerr++; $display("FAIL abort_out[%0d]: got %h required 00000000", n, d);
            end
        end
        load_ramp();
        axi_write(A_START, 32'h1, 4'hF, r);
        axi_write(A_START, 32'h0, 4'hF, r);
        wait_done("rerun");
        for (int n = 0; n < 32; n++) begin
            e = (n == 0) ? 32'h0 : (n == 1) ? 32'h4 : (n == 2) ? 32'h10 : 32'(24 * n - 36);
            axi_read(32'h200 + 32'(4 * n), 0, d, r);
            nvec++;
            if (d !== e) begin
                nerr++; $display("FAIL rerun_out[%0d]: got %h required %h", n, d, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_ramp();
        test_impulse();
        test_negative();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fir_top_axi4lite.md
FIR_TOP_AXI4LITE -- requirements
Module: fir_top_axi4lite

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no parameters.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-high (1 = in reset).
REQ-004 i_axi_awaddr  input  32  write address; i_axi_awvalid input 1; o_axi_awready output 1.
REQ-005 i_axi_awcache input 4 and i_axi_awprot input 3 SHALL be ignored, as SHALL i_axi_arcache input 4 and i_axi_arprot input 3.
REQ-006 i_axi_wdata  input  32; i_axi_wstrb  input  4 byte enables; i_axi_wvalid  input  1; o_axi_wready  output  1.
REQ-007 o_axi_bresp  output  2; o_axi_bvalid  output  1; i_axi_bready  input  1.
REQ-008 i_axi_araddr  input  32; i_axi_arvalid  input  1; o_axi_arready  output  1.
REQ-009 o_axi_rdata  output  32; o_axi_rresp  output  2; o_axi_rvalid  output  1; i_axi_rready  input  1.

Function
REQ-010 Register map (byte addresses, addr[1:0] ignored): 0x000 START rw bit0; 0x004 DONE ro bit0; 0x100+4i IN[i] rw, i=0..31; 0x200+4i OUT[i] ro, i=0..31.
REQ-011 Unmapped reads SHALL return 0; writes to unmapped, DONE or OUT addresses SHALL be discarded; bresp and rresp SHALL always be OKAY (2'b00).
REQ-012 Write channel: awready and wready SHALL pulse high together for one cycle only when awvalid and wvalid are both high and no response is pending; bvalid SHALL rise the next cycle and hold until bready.
REQ-013 Read channel: arready SHALL pulse high for one cycle when arvalid is high and no read response is pending; rvalid and rdata SHALL appear the next cycle and hold stable until rready.
REQ-014 wstrb SHALL gate byte lanes for START and IN writes.
REQ-015 IN[i] SHALL store wdata[15:0] as a signed 16-bit sample; reads of IN return the sample sign-extended to 32 bits.
REQ-016 A START register 0->1 transition while idle SHALL launch a run: DONE cleared the following cycle, FSM IDLE->BUSY.
REQ-017 A START 0->1 transition while BUSY SHALL be ignored; IN writes while BUSY SHALL be discarded.
REQ-018 In BUSY the block SHALL compute one output per cycle, n=0..31: OUT[n] = x[n] + 2*x[n-1] + 2*x[n-2] + x[n-3], with x[k]=IN[k] and x[k]=0 for k<0.
REQ-019 Arithmetic SHALL be signed two's complement, 32-bit result, no saturation or rounding.
REQ-020 After OUT[31] is written the FSM SHALL return to IDLE and set DONE; DONE SHALL read 1 exactly 33 cycles after the cycle that accepted the START write.
REQ-021 DONE SHALL stay set until the next accepted run start or reset; OUT SHALL hold its values in IDLE.

Reset
REQ-022 Reset SHALL asynchronously clear START, DONE, all IN and OUT entries and the FSM (IDLE), and drive awready, wready, bvalid, arready, rvalid and rdata to 0.
REQ-023 Reset asserted during BUSY SHALL abort the run; after release DONE=0 and all OUT=0.
REQ-024 The first AXI transfer SHALL be accepted within 2 cycles of reset release.

Verification
REQ-025 Reset then read DONE, OUT[5], IN[0] -> all 0, rresp OKAY.
REQ-026 IN[i]=4i, START 1 then 0, poll DONE -> DONE=1; OUT[0..3]=0x0,0x4,0x10,0x24; OUT[n]=24n-36 for n>=3; OUT[31]=0x2C4.
REQ-027 Impulse IN[0]=1, others 0 -> OUT[0..3]=1,2,2,1, OUT[4..31]=0.
REQ-028 All IN=0xFFFF -> OUT[0]=0xFFFFFFFF, OUT[1]=0xFFFFFFFD, OUT[2]=0xFFFFFFFB, OUT[3..31]=0xFFFFFFFA.
REQ-029 Second START pulse and an IN write issued 10 cycles into a run -> both ignored, DONE at cycle 33, results equal the REQ-026 values.
REQ-030 Reset pulse 10 cycles into a run -> DONE=0, OUT[0..31]=0, and a subsequent run gives the REQ-026 values.
